// File: rtl/hash_pe_dispatcher.sv
// rtl/hash_pe_dispatcher.sv - fans hash lanes of each input beat out to per-PE serializers and FIFOs
module hash_pe_dispatcher #(
  parameter int ISSUE_W   = 4,
  parameter int NUM_PE    = 4,
  parameter int HASH_BITS = 15,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  localparam int PE_LOG2  = (NUM_PE > 1) ? $clog2(NUM_PE) : 0,
  localparam int LH       = HASH_BITS - PE_LOG2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AW:0]                  cfg_fifo_limit,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_head_addr,
  input  logic [ISSUE_W*HASH_BITS-1:0] in_hash_vec,
  input  logic                         in_delim,
  output logic [NUM_PE-1:0]            out_valid,
  input  logic [NUM_PE-1:0]            out_ready,
  output logic [NUM_PE*ADDR_W-1:0]     out_addr,
  output logic [NUM_PE*LH-1:0]         out_hash,
  output logic [NUM_PE-1:0]            out_delim,
  output logic [NUM_PE-1:0]            out_token
);

  localparam int LW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  typedef enum logic {S_IDLE, S_SERIAL} ser_state_t;

  logic [ADDR_W-1:0]                  beat_addr;
  logic [ISSUE_W*LH-1:0]              beat_hash;
  logic                               beat_delim;
  logic                               accept;
  logic [NUM_PE-1:0]                  pe_ready;
  logic [NUM_PE-1:0][ISSUE_W-1:0]     route_mask;

  assign in_ready = rst_n & (&pe_ready);
  assign accept   = in_valid & in_ready;

  // PE select is the top PE_LOG2 hash bits; shifting by LH yields 0 when NUM_PE=1.
  always_comb begin
    route_mask = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if ((in_hash_vec[i*HASH_BITS +: HASH_BITS] >> LH) == HASH_BITS'(p))
          route_mask[p][i] = 1'b1;
      end
    end
  end

  // Only the bank-local hash bits are kept; routing has already been resolved.
  always_ff @(posedge clk) begin
    if (accept) begin
      beat_addr  <= in_head_addr;
      beat_delim <= in_delim;
      for (int i = 0; i < ISSUE_W; i++)
        beat_hash[i*LH +: LH] <= in_hash_vec[i*HASH_BITS +: LH];
    end
  end

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    ser_state_t          state;
    logic [ISSUE_W-1:0]  mask;
    logic [ISSUE_W-1:0]  mask_next;
    logic [LW-1:0]       lane;
    logic                push;
    logic                final_push;
    logic                pop;
    logic [AW:0]         count;
    logic [AW:0]         lim;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [ADDR_W-1:0]   mem_addr  [DEPTH];
    logic [LH-1:0]       mem_hash  [DEPTH];
    logic                mem_delim [DEPTH];
    logic                mem_token [DEPTH];
    logic [ADDR_W-1:0]   push_addr;
    logic [LH-1:0]       push_hash;
    logic                push_delim;
    logic                push_token;

    always_comb begin
      lane = '0;
      for (int i = ISSUE_W-1; i >= 0; i--)
        if (mask[i]) lane = LW'(i);
    end

    assign mask_next  = mask & ~(ISSUE_W'(1) << lane);
    assign lim        = (cfg_fifo_limit == '0 || cfg_fifo_limit > (AW+1)'(DEPTH))
                        ? (AW+1)'(DEPTH) : cfg_fifo_limit;
    assign push       = (state == S_SERIAL) && (count < lim);
    // An empty mask in SERIAL means a delim-only token; it is always the final item.
    assign final_push = push && (mask_next == '0);
    assign pe_ready[p] = (state == S_IDLE) || final_push;

    assign push_addr  = beat_addr + ADDR_W'(lane);
    assign push_hash  = beat_hash[lane*LH +: LH];
    assign push_delim = beat_delim && (mask_next == '0);
    assign push_token = (mask == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= S_IDLE;
        mask  <= '0;
      end else if (accept) begin
        mask  <= route_mask[p];
        state <= (route_mask[p] != '0 || in_delim) ? S_SERIAL : S_IDLE;
      end else if (push) begin
        mask <= mask_next;
        if (final_push) state <= S_IDLE;
      end
    end

    assign out_valid[p] = (count != '0);
    assign pop          = out_valid[p] & out_ready[p];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_addr[wr_ptr]  <= push_addr;
        mem_hash[wr_ptr]  <= push_hash;
        mem_delim[wr_ptr] <= push_delim;
        mem_token[wr_ptr] <= push_token;
      end
    end

    assign out_addr[p*ADDR_W +: ADDR_W] = mem_addr[rd_ptr];
    assign out_hash[p*LH +: LH]         = mem_hash[rd_ptr];
    assign out_delim[p]                 = out_valid[p] & mem_delim[rd_ptr];
    assign out_token[p]                 = out_valid[p] & mem_token[rd_ptr];
  end

endmodule

// File: tb/tb_hash_pe_dispatcher.sv
// tb/tb_hash_pe_dispatcher.sv - scoreboard bench for hash_pe_dispatcher at default parameters
module tb_hash_pe_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cfg_fifo_limit;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_head_addr;
  logic [59:0] in_hash_vec;
  logic        in_delim;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [127:0] out_addr;
  logic [51:0] out_hash;
  logic [3:0]  out_delim;
  logic [3:0]  out_token;

  hash_pe_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .cfg_fifo_limit(cfg_fifo_limit),
    .in_valid(in_valid), .in_ready(in_ready), .in_head_addr(in_head_addr),
    .in_hash_vec(in_hash_vec), .in_delim(in_delim),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_hash(out_hash), .out_delim(out_delim), .out_token(out_token)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [12:0] hash;
    logic        delim;
    logic        token;
  } exp_t;

  exp_t q [4][$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [59:0] pack4(input logic [14:0] h0, input logic [14:0] h1,
                                        input logic [14:0] h2, input logic [14:0] h3);
    return {h3, h2, h1, h0};
  endfunction

  task automatic expect_entry(input int p, input logic [31:0] a, input logic [12:0] h,
                              input logic d, input logic t);
    exp_t e;
    e.addr = a; e.hash = h; e.delim = d; e.token = t;
    q[p].push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [59:0] h, input logic d, output int waited);
    bit ok;
    in_head_addr = a; in_hash_vec = h; in_delim = d; in_valid = 1'b1;
    waited = 0; ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every accepted output entry is checked against its PE queue.
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    if (rst_n) begin
      for (int p = 0; p < 4; p++) begin
        if (out_valid[p] && out_ready[p]) begin
          n_cmp++;
          if (q[p].size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pe%0d: got addr 0x%0h tok %0b, expected no entry",
                     p, out_addr[p*32 +: 32], out_token[p]);
          end else begin
            e = q[p].pop_front();
            bad = (out_token[p] !== e.token) || (out_delim[p] !== e.delim);
            if (!e.token)
              bad = bad || (out_addr[p*32 +: 32] !== e.addr) || (out_hash[p*13 +: 13] !== e.hash);
            if (bad) begin
              n_err++;
              $display("FAIL entry_pe%0d: got addr 0x%0h hash 0x%0h delim %0b tok %0b, expected addr 0x%0h hash 0x%0h delim %0b tok %0b",
                       p, out_addr[p*32 +: 32], out_hash[p*13 +: 13], out_delim[p], out_token[p],
                       e.addr, e.hash, e.delim, e.token);
            end
          end
        end
      end
    end
  end

  initial begin
    int w1, w2, low, drained;
    bit stale;
    rst_n = 1'b0; cfg_fifo_limit = 3'd0; in_valid = 1'b0; in_head_addr = '0;
    in_hash_vec = '0; in_delim = 1'b0; out_ready = 4'hF;

    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_delim_token", 32'({out_delim, out_token}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'h1);

    // One lane per PE, latency and steady in_ready
    expect_entry(0, 32'h100, 13'h0005, 1'b0, 1'b0);
    expect_entry(1, 32'h101, 13'h0016, 1'b0, 1'b0);
    expect_entry(2, 32'h102, 13'h0027, 1'b0, 1'b0);
    expect_entry(3, 32'h103, 13'h0038, 1'b0, 1'b0);
    @(posedge clk); #1;
    send(32'h100, pack4(15'h0005, 15'h2016, 15'h4027, 15'h6038), 1'b0, w1);
    @(negedge clk);
    chk("lat_t1_valid", 32'(out_valid), 32'h0);
    chk("lat_t1_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    chk("lat_t2_valid", 32'(out_valid), 32'hF);
    chk("lat_t2_ready", 32'(in_ready), 32'h1);

    // Back-to-back beats without a bubble
    for (int b = 0; b < 2; b++) begin
      expect_entry(0, 32'h500 + 32'(b*4),     13'h0005, 1'b0, 1'b0);
      expect_entry(1, 32'h500 + 32'(b*4 + 1), 13'h0016, 1'b0, 1'b0);
      expect_entry(2, 32'h500 + 32'(b*4 + 2), 13'h0027, 1'b0, 1'b0);
      expect_entry(3, 32'h500 + 32'(b*4 + 3), 13'h0038, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    send(32'h500, pack4(15'h0005, 15'h2016, 15'h4027, 15'h6038), 1'b0, w1);
    send(32'h504, pack4(15'h0005, 15'h2016, 15'h4027, 15'h6038), 1'b0, w2);
    chk("b2b_no_bubble", 32'(w2), 32'h0);
    repeat (3) @(negedge clk);

    // All lanes to PE1 with delim; other PEs get tokens
    expect_entry(1, 32'h200, 13'h0001, 1'b0, 1'b0);
    expect_entry(1, 32'h201, 13'h0002, 1'b0, 1'b0);
    expect_entry(1, 32'h202, 13'h0003, 1'b0, 1'b0);
    expect_entry(1, 32'h203, 13'h0004, 1'b1, 1'b0);
    expect_entry(0, 32'h0, 13'h0, 1'b1, 1'b1);
    expect_entry(2, 32'h0, 13'h0, 1'b1, 1'b1);
    expect_entry(3, 32'h0, 13'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    send(32'h200, pack4(15'h2001, 15'h2002, 15'h2003, 15'h2004), 1'b1, w1);
    low = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) break;
      low++;
    end
    chk("delim_ready_low_cycles", 32'(low), 32'd3);
    repeat (3) @(negedge clk);

    // Backpressure on PE1 with occupancy limit 2
    out_ready = 4'b1101;
    cfg_fifo_limit = 3'd2;
    expect_entry(1, 32'h300, 13'h0100, 1'b0, 1'b0);
    expect_entry(1, 32'h301, 13'h0101, 1'b0, 1'b0);
    expect_entry(1, 32'h302, 13'h0102, 1'b0, 1'b0);
    expect_entry(1, 32'h303, 13'h0103, 1'b0, 1'b0);
    @(posedge clk); #1;
    send(32'h300, pack4(15'h2100, 15'h2101, 15'h2102, 15'h2103), 1'b0, w1);
    repeat (8) @(negedge clk);
    chk("limit_in_ready_held", 32'(in_ready), 32'h0);
    chk("limit_out_valid", 32'(out_valid), 32'h2);
    out_ready = 4'hF;
    repeat (6) @(negedge clk);
    chk("limit_released_ready", 32'(in_ready), 32'h1);
    cfg_fifo_limit = 3'd0;

    // Address wrap at the top of the 32-bit space, mixed routing with delim
    expect_entry(3, 32'hFFFF_FFFC, 13'h0AAA, 1'b1, 1'b0);
    expect_entry(0, 32'hFFFF_FFFD, 13'h0123, 1'b0, 1'b0);
    expect_entry(0, 32'hFFFF_FFFE, 13'h1FFF, 1'b1, 1'b0);
    expect_entry(2, 32'hFFFF_FFFF, 13'h1555, 1'b1, 1'b0);
    expect_entry(1, 32'h0, 13'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    send(32'hFFFF_FFFC, pack4(15'h6AAA, 15'h0123, 15'h1FFF, 15'h5555), 1'b1, w1);
    repeat (5) @(negedge clk);

    // Reset with entries queued: nothing stale may emerge afterwards
    out_ready = 4'h0;
    @(posedge clk); #1;
    send(32'h600, pack4(15'h4001, 15'h4002, 15'h4003, 15'h6004), 1'b0, w1);
    repeat (6) @(negedge clk);
    chk("queued_before_reset", 32'(out_valid), 32'hC);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_out_valid", 32'(out_valid), 32'h0);
    chk("reset_mid_in_ready", 32'(in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'hF;
    stale = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid != 4'h0) stale = 1'b1;
    end
    chk("no_stale_after_reset", 32'(stale), 32'h0);
    expect_entry(0, 32'h700, 13'h0005, 1'b0, 1'b0);
    expect_entry(1, 32'h701, 13'h0016, 1'b0, 1'b0);
    expect_entry(2, 32'h702, 13'h0027, 1'b0, 1'b0);
    expect_entry(3, 32'h703, 13'h0038, 1'b0, 1'b0);
    @(posedge clk); #1;
    send(32'h700, pack4(15'h0005, 15'h2016, 15'h4027, 15'h6038), 1'b0, w1);
    chk("post_reset_wait", 32'(w1), 32'h0);
    @(negedge clk);
    chk("post_reset_t1_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("post_reset_t2_valid", 32'(out_valid), 32'hF);

    drained = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) begin
        drained = 1;
        break;
      end
    end
    chk("scoreboard_drained", 32'(drained), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
